// File: rtl/csr_arb_pkg.sv
// Shared widths, FSM state type and helpers for the two-requester CSR arbiter.
package csr_arb_pkg;

    localparam int unsigned CSR_AW         = 8;
    localparam int unsigned CSR_DW         = 32;
    localparam int unsigned NUM_REQ        = 2;
    localparam int unsigned RD_LATENCY_MAX = 15;
    localparam int unsigned CNT_W          = $clog2(RD_LATENCY_MAX + 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRd
    } csr_arb_state_e;

    function automatic logic [NUM_REQ-1:0] idx2onehot(input logic idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/csr_rr_arb.sv
// Two-way round-robin pick: the pointer only matters on a conflict and, after each
// grant, moves to the requester that lost.
module csr_rr_arb
    import csr_arb_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_update,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_idx
);

    logic r_ptr;

    always_comb begin
        o_idx = 1'b0;
        if (i_req == 2'b11) begin
            o_idx = r_ptr;
        end else begin
            o_idx = i_req[1];
        end
        o_gnt = {o_idx, ~o_idx} & {NUM_REQ{|i_req}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (i_update) begin
            r_ptr <= ~o_idx;
        end
    end

endmodule

// File: rtl/csr_arbiter.sv
// Two-requester CSR bus arbiter: round-robin grant, one-cycle CSR strobe, read-latency wait.
// Optional feature macro CSR_ARB_WR_ACK_EN: writes also return a rsp_valid pulse.
module csr_arbiter
    import csr_arb_pkg::*;
#(
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ-1:0]             req_write,
    input  logic [NUM_REQ-1:0][CSR_AW-1:0] req_address,
    input  logic [NUM_REQ-1:0][CSR_DW-1:0] req_wr_data,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [CSR_DW-1:0]              rsp_rd_data,
    output logic [CSR_AW-1:0]              csr_address,
    output logic [CSR_DW-1:0]              csr_wr_data,
    output logic                           csr_write,
    output logic                           csr_read,
    input  logic [CSR_DW-1:0]              csr_rd_data
);

`ifdef CSR_ARB_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAT = CNT_W'(RD_LATENCY);

    csr_arb_state_e     r_state;
    csr_arb_state_e     w_state_next;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_idx;
    logic               w_hs;
    logic               r_idx;
    logic               r_op_write;
    logic [CNT_W-1:0]   r_cnt;
    logic [CSR_AW-1:0]  r_csr_address;
    logic [CSR_DW-1:0]  r_csr_wr_data;
    logic               r_csr_write;
    logic               r_csr_read;
    logic [NUM_REQ-1:0] r_rsp_valid;
    logic [CSR_DW-1:0]  r_rsp_rd_data;

    assign w_hs = (r_state == StIdle) && (|req_valid);

    csr_rr_arb u_rr_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_req    (req_valid),
        .i_update (w_hs),
        .o_gnt    (w_gnt),
        .o_idx    (w_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_hs) w_state_next = StIssue;
            StIssue:  w_state_next = r_op_write ? StIdle : StWaitRd;
            StWaitRd: if (r_cnt == LAT) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        req_ready = '0;
        if (r_state == StIdle) begin
            req_ready = w_gnt;
        end
    end

    // Address/data go straight onto the bus registers at the handshake so the strobe
    // cycle (ISSUE) already presents them; they then hold until the next transaction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx         <= 1'b0;
            r_op_write    <= 1'b0;
            r_cnt         <= '0;
            r_csr_address <= '0;
            r_csr_wr_data <= '0;
            r_csr_write   <= 1'b0;
            r_csr_read    <= 1'b0;
            r_rsp_valid   <= '0;
            r_rsp_rd_data <= '0;
        end else begin
            r_csr_write <= 1'b0;
            r_csr_read  <= 1'b0;
            r_rsp_valid <= '0;
            unique case (r_state)
                StIdle: begin
                    if (w_hs) begin
                        r_idx         <= w_idx;
                        r_op_write    <= req_write[w_idx];
                        r_csr_address <= req_address[w_idx];
                        r_csr_wr_data <= req_wr_data[w_idx];
                        r_csr_write   <= req_write[w_idx];
                        r_csr_read    <= ~req_write[w_idx];
                    end
                end
                StIssue: begin
                    if (!r_op_write) begin
                        r_cnt <= CNT_W'(1);
                    end else if (WR_ACK) begin
                        r_rsp_valid <= idx2onehot(r_idx);
                    end
                end
                StWaitRd: begin
                    if (r_cnt == LAT) begin
                        r_cnt         <= '0;
                        r_rsp_valid   <= idx2onehot(r_idx);
                        r_rsp_rd_data <= csr_rd_data;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign csr_address = r_csr_address;
    assign csr_wr_data = r_csr_wr_data;
    assign csr_write   = r_csr_write;
    assign csr_read    = r_csr_read;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_rd_data = r_rsp_rd_data;

endmodule

// File: tb/tb_csr_arbiter.sv
// Self-checking bench for csr_arbiter: directed vector table, randomized traffic against a
// transaction-level model, reset-abort sequence and a RD_LATENCY=4 instance.
module tb_csr_arbiter;

`ifdef CSR_ARB_WR_ACK_EN
    localparam bit WR_ACK = 1'b1;
`else
    localparam bit WR_ACK = 1'b0;
`endif
    localparam int unsigned LAT = 1;
    localparam logic [1:0] K0 = WR_ACK ? 2'b01 : 2'b00;
    localparam logic [1:0] K1 = WR_ACK ? 2'b10 : 2'b00;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [1:0]       req_valid = '0, req_write = '0;
    logic [1:0][7:0]  req_address = '0;
    logic [1:0][31:0] req_wr_data = '0;
    logic [31:0]      csr_rd_data = '0;
    logic [1:0]       req_ready, rsp_valid;
    logic [31:0]      rsp_rd_data, csr_wr_data;
    logic [7:0]       csr_address;
    logic             csr_write, csr_read;

    logic [1:0]       l4_valid = '0, l4_write = '0, l4_ready, l4_rsp;
    logic [1:0][7:0]  l4_addr = '0;
    logic [1:0][31:0] l4_wdata = '0;
    logic [31:0]      l4_rd = '0, l4_rdata, l4_cwdata;
    logic [7:0]       l4_caddr;
    logic             l4_cwr, l4_crd;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    csr_arbiter #(.RD_LATENCY(LAT)) u_dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write),
        .req_address(req_address), .req_wr_data(req_wr_data), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rd_data(rsp_rd_data), .csr_address(csr_address),
        .csr_wr_data(csr_wr_data), .csr_write(csr_write), .csr_read(csr_read),
        .csr_rd_data(csr_rd_data)
    );

    csr_arbiter #(.RD_LATENCY(4)) u_dut4 (
        .clk(clk), .reset_n(reset_n), .req_valid(l4_valid), .req_write(l4_write),
        .req_address(l4_addr), .req_wr_data(l4_wdata), .req_ready(l4_ready),
        .rsp_valid(l4_rsp), .rsp_rd_data(l4_rdata), .csr_address(l4_caddr),
        .csr_wr_data(l4_cwdata), .csr_write(l4_cwr), .csr_read(l4_crd),
        .csr_rd_data(l4_rd)
    );

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] rd_hash(input int c);
        return (32'(c) * 32'h9E3779B1) ^ 32'h5BD1E995;
    endfunction

    typedef struct {
        logic [1:0]  valid, write;
        logic [7:0]  a0, a1;
        logic [31:0] d0, d1, rd;
        logic [1:0]  e_ready;
        logic        e_wr, e_rd;
        logic [7:0]  e_addr;
        logic [31:0] e_wdata;
        logic [1:0]  e_rsp;
        logic [31:0] e_rdata;
    } vec_t;
    vec_t vecs[$];

    // Transaction-level reference: when the FSM is next free, what is strobed when,
    // and which cycle returns which response.
    int          m_free, m_stb_cyc, m_rsp_cyc, m_cap_cyc;
    bit          m_ptr, m_stb_wr, m_rsp_idx, m_rsp_rd;
    logic [7:0]  m_stb_addr, m_addr;
    logic [31:0] m_stb_data, m_wdata, m_rdata;
    logic [1:0]  m_exp_ready = '0;

    task automatic m_reset();
        m_free = 0; m_stb_cyc = -1; m_rsp_cyc = -1; m_cap_cyc = 0;
        m_ptr = 0; m_stb_wr = 0; m_rsp_idx = 0; m_rsp_rd = 0;
        m_stb_addr = '0; m_addr = '0; m_stb_data = '0; m_wdata = '0; m_rdata = '0;
        m_exp_ready = '0;
    endtask

    task automatic model_check();
        logic [1:0] exp_rsp;
        bit         win, wr;
        if (cyc == m_stb_cyc) begin
            m_addr  = m_stb_addr;
            m_wdata = m_stb_data;
        end
        exp_rsp = '0;
        if (cyc == m_rsp_cyc) begin
            exp_rsp[m_rsp_idx] = 1'b1;
            if (m_rsp_rd) m_rdata = rd_hash(m_cap_cyc);
        end
        m_exp_ready = '0;
        if (cyc >= m_free && req_valid != 2'b00) begin
            win = (req_valid == 2'b11) ? m_ptr : req_valid[1];
            m_exp_ready[win] = 1'b1;
            m_ptr = !win;
            wr = req_write[win];
            m_stb_cyc = cyc + 1; m_stb_wr = wr;
            m_stb_addr = req_address[win]; m_stb_data = req_wr_data[win];
            m_free = cyc + (wr ? 2 : 2 + LAT);
            m_rsp_idx = win;
            if (!wr) begin
                m_rsp_cyc = cyc + 2 + LAT; m_rsp_rd = 1; m_cap_cyc = cyc + 1 + LAT;
            end else if (WR_ACK) begin
                m_rsp_cyc = cyc + 2; m_rsp_rd = 0;
            end
        end
        chk("rnd req_ready", 32'(req_ready), 32'(m_exp_ready));
        chk("rnd csr_write", 32'(csr_write), 32'(cyc == m_stb_cyc && m_stb_wr));
        chk("rnd csr_read", 32'(csr_read), 32'(cyc == m_stb_cyc && !m_stb_wr));
        chk("rnd csr_address", 32'(csr_address), 32'(m_addr));
        chk("rnd csr_wr_data", csr_wr_data, m_wdata);
        chk("rnd rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
        chk("rnd rsp_rd_data", rsp_rd_data, m_rdata);
    endtask

    task automatic new_req(input int i);
        req_valid[i]   = 1'b1;
        req_write[i]   = 1'($urandom_range(1, 0));
        req_address[i] = 8'($urandom);
        req_wr_data[i] = $urandom;
    endtask

    task automatic do_reset();
        req_valid = '0; req_write = '0; csr_rd_data = '0;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        m_reset();
    endtask

    function automatic void add(input logic [1:0] v, w, input logic [7:0] a0, a1,
                                input logic [31:0] d0, d1, rd, input logic [1:0] er,
                                input logic ew, erd, input logic [7:0] ea,
                                input logic [31:0] ewd, input logic [1:0] ersp,
                                input logic [31:0] erdat);
        vecs.push_back('{v, w, a0, a1, d0, d1, rd, er, ew, erd, ea, ewd, ersp, erdat});
    endfunction

    initial begin
        // Single write, single read, alternating writes, then a late request that drops.
        add(2'b01, 2'b01, 8'h10, 8'h00, 32'hDEADBEEF, 32'h0, 32'h0,
            2'b01, 1'b0, 1'b0, 8'h00, 32'h0, 2'b00, 32'h0);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0,
            2'b00, 1'b1, 1'b0, 8'h10, 32'hDEADBEEF, 2'b00, 32'h0);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF, K0, 32'h0);
        add(2'b10, 2'b00, 8'h00, 8'h04, 32'h0, 32'h0, 32'h0,
            2'b10, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF, 2'b00, 32'h0);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'hBAD0BAD0,
            2'b00, 1'b0, 1'b1, 8'h04, 32'h0, 2'b00, 32'h0);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h12345678,
            2'b00, 1'b0, 1'b0, 8'h04, 32'h0, 2'b00, 32'h0);
        add(2'b11, 2'b11, 8'h20, 8'h24, 32'h11111111, 32'h22222222, 32'h0,
            2'b01, 1'b0, 1'b0, 8'h04, 32'h0, 2'b10, 32'h12345678);
        add(2'b11, 2'b11, 8'h20, 8'h24, 32'h11111111, 32'h22222222, 32'h0,
            2'b00, 1'b1, 1'b0, 8'h20, 32'h11111111, 2'b00, 32'h12345678);
        add(2'b11, 2'b11, 8'h20, 8'h24, 32'h11111111, 32'h22222222, 32'h0,
            2'b10, 1'b0, 1'b0, 8'h20, 32'h11111111, K0, 32'h12345678);
        add(2'b11, 2'b11, 8'h20, 8'h24, 32'h11111111, 32'h22222222, 32'h0,
            2'b00, 1'b1, 1'b0, 8'h24, 32'h22222222, 2'b00, 32'h12345678);
        add(2'b11, 2'b11, 8'h20, 8'h24, 32'h11111111, 32'h22222222, 32'h0,
            2'b01, 1'b0, 1'b0, 8'h24, 32'h22222222, K1, 32'h12345678);
        add(2'b11, 2'b11, 8'h20, 8'h24, 32'h11111111, 32'h22222222, 32'h0,
            2'b00, 1'b1, 1'b0, 8'h20, 32'h11111111, 2'b00, 32'h12345678);
        add(2'b11, 2'b11, 8'h20, 8'h24, 32'h11111111, 32'h22222222, 32'h0,
            2'b10, 1'b0, 1'b0, 8'h20, 32'h11111111, K0, 32'h12345678);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0,
            2'b00, 1'b1, 1'b0, 8'h24, 32'h22222222, 2'b00, 32'h12345678);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b0, 8'h24, 32'h22222222, K1, 32'h12345678);
        add(2'b01, 2'b00, 8'h33, 8'h00, 32'h0, 32'h0, 32'h0,
            2'b01, 1'b0, 1'b0, 8'h24, 32'h22222222, 2'b00, 32'h12345678);
        add(2'b10, 2'b00, 8'h00, 8'h55, 32'h0, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b1, 8'h33, 32'h0, 2'b00, 32'h12345678);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'hCAFEF00D,
            2'b00, 1'b0, 1'b0, 8'h33, 32'h0, 2'b00, 32'h12345678);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b0, 8'h33, 32'h0, 2'b01, 32'hCAFEF00D);
        add(2'b00, 2'b00, 8'h00, 8'h00, 32'h0, 32'h0, 32'h0,
            2'b00, 1'b0, 1'b0, 8'h33, 32'h0, 2'b00, 32'hCAFEF00D);

        // Reset values
        tick(); tick(); tick();
        chk("reset csr_write", 32'(csr_write), 32'h0);
        chk("reset csr_read", 32'(csr_read), 32'h0);
        chk("reset csr_address", 32'(csr_address), 32'h0);
        chk("reset csr_wr_data", csr_wr_data, 32'h0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
        chk("reset rsp_rd_data", rsp_rd_data, 32'h0);
        chk("reset lat4 rsp_valid", 32'(l4_rsp), 32'h0);
        reset_n = 1'b1;

        foreach (vecs[k]) begin
            req_valid = vecs[k].valid; req_write = vecs[k].write;
            req_address = {vecs[k].a1, vecs[k].a0};
            req_wr_data = {vecs[k].d1, vecs[k].d0};
            csr_rd_data = vecs[k].rd;
            @(negedge clk);
            chk($sformatf("vec%0d req_ready", k), 32'(req_ready), 32'(vecs[k].e_ready));
            chk($sformatf("vec%0d csr_write", k), 32'(csr_write), 32'(vecs[k].e_wr));
            chk($sformatf("vec%0d csr_read", k), 32'(csr_read), 32'(vecs[k].e_rd));
            chk($sformatf("vec%0d csr_address", k), 32'(csr_address), 32'(vecs[k].e_addr));
            chk($sformatf("vec%0d csr_wr_data", k), csr_wr_data, vecs[k].e_wdata);
            chk($sformatf("vec%0d rsp_valid", k), 32'(rsp_valid), 32'(vecs[k].e_rsp));
            chk($sformatf("vec%0d rsp_rd_data", k), rsp_rd_data, vecs[k].e_rdata);
            tick();
        end

        // Randomized traffic against the model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (m_exp_ready[i]) begin
                    if ($urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
                    else new_req(i);
                end else if (req_valid[i]) begin
                    if ($urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(1, 0) == 0) begin
                    new_req(i);
                end
            end
            csr_rd_data = rd_hash(cyc);
            @(negedge clk);
            model_check();
            tick();
        end

        // Reset in WAIT_RD aborts the read; req 1 is served first afterwards
        req_valid = '0;
        repeat (10) tick();
        req_valid = 2'b01; req_write = 2'b00;
        req_address = {8'h99, 8'h77}; req_wr_data = {32'h0, 32'h0F0F0F0F};
        csr_rd_data = '0;
        @(negedge clk);
        chk("abort grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = 2'b10;
        @(negedge clk);
        chk("abort issue csr_read", 32'(csr_read), 32'h1);
        chk("abort issue csr_address", 32'(csr_address), 32'h77);
        tick();
        csr_rd_data = 32'h5555AAAA;
        #2 reset_n = 1'b0;
        #1;
        chk("abort async csr_read", 32'(csr_read), 32'h0);
        chk("abort async csr_address", 32'(csr_address), 32'h0);
        chk("abort async csr_wr_data", csr_wr_data, 32'h0);
        chk("abort async rsp_valid", 32'(rsp_valid), 32'h0);
        chk("abort async rsp_rd_data", rsp_rd_data, 32'h0);
        tick();
        tick();
        reset_n = 1'b1;
        csr_rd_data = 32'h0;
        @(negedge clk);
        chk("abort regrant req1", 32'(req_ready), 32'h2);
        chk("abort no rsp r0", 32'(rsp_valid), 32'h0);
        tick();
        req_valid = 2'b00;
        @(negedge clk);
        chk("abort no rsp r1", 32'(rsp_valid), 32'h0);
        chk("abort r1 csr_address", 32'(csr_address), 32'h99);
        tick();
        csr_rd_data = 32'h600DCAFE;
        @(negedge clk);
        chk("abort no rsp r2", 32'(rsp_valid), 32'h0);
        tick();
        @(negedge clk);
        chk("abort req1 rsp_valid", 32'(rsp_valid), 32'h2);
        chk("abort req1 rsp_rd_data", rsp_rd_data, 32'h600DCAFE);
        tick();

        // RD_LATENCY=4: response six cycles after the handshake
        l4_valid = 2'b01; l4_write = 2'b00; l4_addr = {8'h00, 8'h42};
        @(negedge clk);
        chk("lat4 grant", 32'(l4_ready), 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            l4_valid = 2'b10; l4_write = 2'b10;
            l4_rd = 32'hA0000000 | 32'(k);
            @(negedge clk);
            chk($sformatf("lat4 c%0d req_ready", k), 32'(l4_ready), 32'h0);
            chk($sformatf("lat4 c%0d csr_read", k), 32'(l4_crd), 32'(k == 1));
            chk($sformatf("lat4 c%0d rsp_valid", k), 32'(l4_rsp), 32'h0);
        end
        tick();
        l4_rd = 32'h0;
        @(negedge clk);
        chk("lat4 rsp_valid", 32'(l4_rsp), 32'h1);
        chk("lat4 rsp_rd_data", l4_rdata, 32'hA0000005);
        chk("lat4 next grant", 32'(l4_ready), 32'h2);
        tick();
        l4_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
